// File: rtl/seg7_pkg.sv
// Shared segment codes, FSM state type and width helper for the seven-segment scanner.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_hex7seg.sv
// Hex nibble to active-low gfedcba segment pattern.
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Tick-driven multiplexer for a common-anode multi-digit seven-segment display with
// frame-synchronous shadowing, leading-zero blanking and inter-digit dead time.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned BLANK_TICKS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned      IDX_W    = (DIGITS > 1) ? clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [3:0]       LAST_CNT = (BLANK_TICKS == 0) ? 4'd0 : 4'(BLANK_TICKS - 1);

  state_t              state, state_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  logic [3:0]          cnt, cnt_nx;
  logic [4*DIGITS-1:0] sh_val, sh_val_nx;
  logic [DIGITS-1:0]   sh_dp, sh_dp_nx;
  logic                sh_lz, sh_lz_nx;
  logic                done_nx;

  logic [3:0]          nib;
  logic [6:0]          dec;
  logic                suppress;
  logic [DIGITS-1:0]   an_nx;
  logic [6:0]          seg_nx;
  logic                dp_nx;

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    cnt_nx    = cnt;
    sh_val_nx = sh_val;
    sh_dp_nx  = sh_dp;
    sh_lz_nx  = sh_lz;
    done_nx   = 1'b0;
    if (!enable) begin
      state_nx = ST_BLANK;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else if (tick) begin
      case (state)
        ST_BLANK: begin
          if (BLANK_TICKS == 0 || cnt == LAST_CNT) begin
            state_nx = ST_DRIVE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
        ST_DRIVE: begin
          idx_nx   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
          state_nx = (BLANK_TICKS == 0) ? ST_DRIVE : ST_BLANK;
          done_nx  = (idx == LAST_IDX);
        end
        default: state_nx = ST_BLANK;
      endcase
      // Shadow load happens on the same edge as the first digit of a frame, so the
      // registered pins below must be decoded from the next-state shadow values.
      if (state_nx == ST_DRIVE && idx_nx == '0) begin
        sh_val_nx = value;
        sh_dp_nx  = dp_in;
        sh_lz_nx  = blank_lz;
      end
    end
  end

  assign nib      = sh_val_nx[4*idx_nx +: 4];
  assign suppress = sh_lz_nx && (idx_nx != '0) && ((sh_val_nx >> (4*idx_nx)) == '0);

  hex7seg u_hex7seg (
    .nibble (nib),
    .seg    (dec)
  );

  always_comb begin
    an_nx  = '1;
    seg_nx = SEG_OFF;
    dp_nx  = 1'b1;
    if (state_nx == ST_DRIVE) begin
      dp_nx = ~sh_dp_nx[idx_nx];
      if (suppress) begin
        // Blanked digit still lights its anode when its decimal point is requested.
        an_nx[idx_nx] = ~sh_dp_nx[idx_nx];
      end else begin
        an_nx[idx_nx] = 1'b0;
        seg_nx        = dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_BLANK;
      idx        <= '0;
      cnt        <= '0;
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_lz      <= 1'b0;
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      sh_val     <= sh_val_nx;
      sh_dp      <= sh_dp_nx;
      sh_lz      <= sh_lz_nx;
      an         <= an_nx;
      seg        <= seg_nx;
      dp         <= dp_nx;
      frame_done <= done_nx;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: default dead time and zero dead time instances
// checked against a slot-arithmetic reference model.
module tb_seg7_scan;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        enable = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;

  logic [3:0]  an_o [2];
  logic [6:0]  seg_o [2];
  logic        dp_o [2];
  logic        fd_o [2];

  always #5 clk = ~clk;

  seg7_scan #(.DIGITS(4), .BLANK_TICKS(1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an_o[0]), .seg(seg_o[0]), .dp(dp_o[0]), .frame_done(fd_o[0])
  );

  seg7_scan #(.DIGITS(4), .BLANK_TICKS(0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an_o[1]), .seg(seg_o[1]), .dp(dp_o[1]), .frame_done(fd_o[1])
  );

  int checks = 0;
  int passes = 0;

  // Reference model: ticks since reset/enable, plus the values latched at frame start.
  int          bt [2] = '{1, 0};
  int          kt [2] = '{0, 0};
  logic [15:0] sv [2];
  logic [3:0]  sd [2];
  logic        sl [2];
  logic [6:0]  hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic void model_tick();
    for (int m = 0; m < 2; m++) begin
      kt[m] = kt[m] + 1;
      if ((kt[m] - 1) % (D * (bt[m] + 1)) == 0) begin
        sv[m] = value;
        sd[m] = dp_in;
        sl[m] = blank_lz;
      end
    end
  endfunction

  function automatic void expect_out(input int m, output logic [3:0] ean,
                                     output logic [6:0] eseg, output logic edp,
                                     output logic edone);
    int len;
    int p;
    int d;
    logic [15:0] v;
    len   = D * (bt[m] + 1);
    ean   = 4'hF;
    eseg  = 7'h7F;
    edp   = 1'b1;
    edone = 1'b0;
    if (kt[m] > 0) begin
      p = (kt[m] - 1) % len;
      if (p % (bt[m] + 1) == 0) begin
        d   = p / (bt[m] + 1);
        v   = sv[m] >> (4 * d);
        edp = ~sd[m][d];
        if (sl[m] && d > 0 && v == 16'd0) begin
          if (sd[m][d]) ean[d] = 1'b0;
        end else begin
          ean[d] = 1'b0;
          eseg   = hex_tab[v[3:0]];
        end
      end
      if (kt[m] >= 2 && (kt[m] - 2) % len == (D - 1) * (bt[m] + 1)) edone = 1'b1;
    end
  endfunction

  task automatic tick_once(input int idle);
    repeat (idle) @(posedge clk);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    model_tick();
    #1 tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] ean; logic [6:0] eseg; logic edp, edone;
    rst = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      expect_out(m, ean, eseg, edp, edone);
      checks++;
      if ({an_o[m], seg_o[m], dp_o[m], fd_o[m]} !== {ean, eseg, edp, edone})
        $display("FAIL reset dut%0d: an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                 m, an_o[m], seg_o[m], dp_o[m], fd_o[m], ean, eseg, edp, edone);
      else passes++;
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_pattern();
    logic [3:0] an_seq [8] = '{4'b1110, 4'b1111, 4'b1101, 4'b1111,
                               4'b1011, 4'b1111, 4'b0111, 4'b1111};
    logic [6:0] seg_seq [8] = '{7'b0001110, 7'h7F, 7'b0001000, 7'h7F,
                                7'b0100100, 7'h7F, 7'b1111001, 7'h7F};
    logic [3:0] ean; logic [6:0] eseg; logic edp, edone;
    value = 16'h12AF; dp_in = 4'b0000; blank_lz = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick_once(9);
      checks++;
      if (an_o[0] !== an_seq[k] || seg_o[0] !== seg_seq[k] || fd_o[0] !== (k == 7))
        $display("FAIL pattern tick%0d: an=%b seg=%b fd=%b, want an=%b seg=%b fd=%b",
                 k + 1, an_o[0], seg_o[0], fd_o[0], an_seq[k], seg_seq[k], (k == 7));
      else passes++;
      expect_out(1, ean, eseg, edp, edone);
      checks++;
      if ({an_o[1], seg_o[1], dp_o[1], fd_o[1]} !== {ean, eseg, edp, edone})
        $display("FAIL pattern dut1 tick%0d: an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                 k + 1, an_o[1], seg_o[1], dp_o[1], fd_o[1], ean, eseg, edp, edone);
      else passes++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (fd_o[0] !== 1'b0) $display("FAIL frame_done_width: fd=%b, want 0", fd_o[0]);
    else passes++;
  endtask

  task automatic test_lz();
    logic [3:0] ean; logic [6:0] eseg; logic edp, edone;
    value = 16'h0007; dp_in = 4'b0100; blank_lz = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick_once(2);
      for (int m = 0; m < 2; m++) begin
        expect_out(m, ean, eseg, edp, edone);
        checks++;
        if ({an_o[m], seg_o[m], dp_o[m], fd_o[m]} !== {ean, eseg, edp, edone})
          $display("FAIL lz dut%0d tick%0d: an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                   m, k, an_o[m], seg_o[m], dp_o[m], fd_o[m], ean, eseg, edp, edone);
        else passes++;
      end
      if (k == 5) begin
        checks++;
        if (an_o[0] !== 4'b1011 || seg_o[0] !== 7'h7F || dp_o[0] !== 1'b0)
          $display("FAIL lz_digit2: an=%b seg=%b dp=%b, want an=1011 seg=1111111 dp=0",
                   an_o[0], seg_o[0], dp_o[0]);
        else passes++;
      end
    end
  endtask

  task automatic test_shadow();
    logic [3:0] ean; logic [6:0] eseg; logic edp, edone;
    value = 16'h1111; dp_in = 4'b0000; blank_lz = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 6) value = 16'h2222;
      tick_once(1);
      for (int m = 0; m < 2; m++) begin
        expect_out(m, ean, eseg, edp, edone);
        checks++;
        if ({an_o[m], seg_o[m], dp_o[m], fd_o[m]} !== {ean, eseg, edp, edone})
          $display("FAIL shadow dut%0d tick%0d: an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                   m, k, an_o[m], seg_o[m], dp_o[m], fd_o[m], ean, eseg, edp, edone);
        else passes++;
      end
      if (k == 7 || k == 9) begin
        checks++;
        if (seg_o[0] !== ((k == 7) ? 7'b1111001 : 7'b0100100))
          $display("FAIL shadow_seg tick%0d: seg=%b, want %b", k, seg_o[0],
                   (k == 7) ? 7'b1111001 : 7'b0100100);
        else passes++;
      end
    end
    // Finish the frame so both instances start the next test at a frame boundary.
    for (int k = 0; k < 7; k++) tick_once(0);
  endtask

  task automatic test_no_dead_time();
    logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    value = 16'h8888; dp_in = 4'b0000; blank_lz = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick_once(3);
      checks++;
      if (an_o[1] !== an_seq[k] || seg_o[1] !== 7'b0000000)
        $display("FAIL no_dead_time tick%0d: an=%b seg=%b, want an=%b seg=0000000",
                 k + 1, an_o[1], seg_o[1], an_seq[k]);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ean; logic [6:0] eseg; logic edp, edone;
    value = 16'h5C3E; dp_in = 4'b1010; blank_lz = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      model_tick();
      #1;
      for (int m = 0; m < 2; m++) begin
        expect_out(m, ean, eseg, edp, edone);
        checks++;
        if ({an_o[m], seg_o[m], dp_o[m], fd_o[m]} !== {ean, eseg, edp, edone})
          $display("FAIL back_to_back dut%0d cyc%0d: an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                   m, c, an_o[m], seg_o[m], dp_o[m], fd_o[m], ean, eseg, edp, edone);
        else passes++;
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] ean; logic [6:0] eseg; logic edp, edone;
    int gap;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      value    = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
      dp_in    = 4'($urandom);
      blank_lz = 1'($urandom);
      tick_once(0);
      for (int m = 0; m < 2; m++) begin
        expect_out(m, ean, eseg, edp, edone);
        checks++;
        if ({an_o[m], seg_o[m], dp_o[m], fd_o[m]} !== {ean, eseg, edp, edone})
          $display("FAIL random dut%0d k=%0d: an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                   m, kt[m], an_o[m], seg_o[m], dp_o[m], fd_o[m], ean, eseg, edp, edone);
        else passes++;
      end
      gap = $urandom_range(1, 5);
      repeat (gap) @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        expect_out(m, ean, eseg, edp, edone);
        checks++;
        if ({an_o[m], seg_o[m], dp_o[m], fd_o[m]} !== {ean, eseg, edp, 1'b0})
          $display("FAIL hold dut%0d k=%0d: an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=0",
                   m, kt[m], an_o[m], seg_o[m], dp_o[m], fd_o[m], ean, eseg, edp);
        else passes++;
      end
    end
  endtask

  task automatic test_enable();
    logic [3:0] ean; logic [6:0] eseg; logic edp, edone;
    int guard;
    guard = 0;
    while ((kt[0] == 0 || (kt[0] - 1) % 8 != 2) && guard < 10) begin
      tick_once(1);
      guard++;
    end
    checks++;
    if (an_o[0] !== 4'b1101) $display("FAIL enable_setup: an=%b, want 1101", an_o[0]);
    else passes++;
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    kt[0] = 0;
    kt[1] = 0;
    #1;
    checks++;
    if (an_o[0] !== 4'b1111 || seg_o[0] !== 7'h7F || an_o[1] !== 4'b1111 || fd_o[0] !== 1'b0)
      $display("FAIL enable_off: an=%b/%b seg=%b fd=%b, want an=1111/1111 seg=1111111 fd=0",
               an_o[0], an_o[1], seg_o[0], fd_o[0]);
    else passes++;
    @(negedge clk);
    enable = 1'b1;
    value  = 16'h3D0B; dp_in = 4'b0001; blank_lz = 1'b0;
    tick_once(2);
    for (int m = 0; m < 2; m++) begin
      expect_out(m, ean, eseg, edp, edone);
      checks++;
      if ({an_o[m], seg_o[m], dp_o[m], fd_o[m]} !== {ean, eseg, edp, edone})
        $display("FAIL enable_on dut%0d: an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                 m, an_o[m], seg_o[m], dp_o[m], fd_o[m], ean, eseg, edp, edone);
      else passes++;
    end
    checks++;
    if (an_o[0] !== 4'b1110 || seg_o[0] !== 7'b0000011 || dp_o[0] !== 1'b0)
      $display("FAIL enable_fresh: an=%b seg=%b dp=%b, want an=1110 seg=0000011 dp=0",
               an_o[0], seg_o[0], dp_o[0]);
    else passes++;
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while ((kt[0] == 0 || kt[0] % 8 != 7) && guard < 10) begin
      tick_once(1);
      guard++;
    end
    tick_once(1);
    checks++;
    if (fd_o[0] !== 1'b1) $display("FAIL areset_setup: fd=%b, want 1", fd_o[0]);
    else passes++;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (an_o[0] !== 4'b1111 || seg_o[0] !== 7'h7F || dp_o[0] !== 1'b1 || fd_o[0] !== 1'b0 ||
        an_o[1] !== 4'b1111 || fd_o[1] !== 1'b0)
      $display("FAIL areset: an=%b/%b seg=%b dp=%b fd=%b/%b, want an=1111/1111 seg=1111111 dp=1 fd=0/0",
               an_o[0], an_o[1], seg_o[0], dp_o[0], fd_o[0], fd_o[1]);
    else passes++;
    kt[0] = 0;
    kt[1] = 0;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    checks++;
    if (an_o[0] !== 4'b1111 || fd_o[0] !== 1'b0)
      $display("FAIL areset_hold: an=%b fd=%b, want an=1111 fd=0", an_o[0], fd_o[0]);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_lz();
    test_shadow();
    test_no_dead_time();
    test_back_to_back();
    test_random();
    test_enable();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
